// File: rtl/parity_frame_gen.sv
// parity_frame_gen: handshaked frame parity generator.
// Takes FRAME_LEN words of WIDTH bits and emits one parity bit per frame.
// The parity mode (odd/even) is latched from the first word of each frame.
// Optional checker mode: define PARITY_FRAME_CHECK_EN to add chk_bit/par_err.
module parity_frame_gen #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             odd_sel,
    input  logic             frame_abort,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             par_bit,
`ifdef PARITY_FRAME_CHECK_EN
    input  logic             chk_bit,
    output logic             par_err,
`endif
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t          state;
    logic [WC_W-1:0] wcnt;
    logic            acc;
    logic            mode;

    logic word_par;
    logic cur_mode;
    logic frame_par;
    logic out_bit;

    // Parity of the incoming word folded into the running frame parity; the
    // first word of a frame uses odd_sel directly since mode isn't latched yet.
    always_comb begin
        word_par  = ^in_data;
        cur_mode  = (wcnt == '0) ? odd_sel : mode;
        frame_par = acc ^ word_par;
        out_bit   = frame_par ^ cur_mode;
    end

    // Frame control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            par_valid <= 1'b0;
            par_bit   <= 1'b0;
            frame_cnt <= '0;
            wcnt      <= '0;
            acc       <= 1'b0;
            mode      <= 1'b0;
`ifdef PARITY_FRAME_CHECK_EN
            par_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                ACCUM: begin
                    if (frame_abort) begin
                        // Abort wins over a same-cycle word.
                        wcnt <= '0;
                        acc  <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        if (wcnt == '0)
                            mode <= odd_sel;
                        if (wcnt == LAST_IDX) begin
                            wcnt      <= '0;
                            acc       <= frame_par;
                            par_bit   <= out_bit;
                            par_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            frame_cnt <= frame_cnt + 1'b1;
`ifdef PARITY_FRAME_CHECK_EN
                            par_err   <= (chk_bit != out_bit);
`endif
                            state     <= OUT;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                            acc  <= frame_par;
                        end
                    end
                end
                OUT: begin
                    // Completed frame is always delivered; abort is ignored here.
                    if (par_valid && par_ready) begin
                        par_valid <= 1'b0;
                        wcnt      <= '0;
                        acc       <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef PARITY_FRAME_CHECK_EN
                        par_err   <= 1'b0;
`endif
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_gen.sv
// Self-checking bench for parity_frame_gen: a queue-based frame model checked
// every cycle, directed frames with literal expectations, random traffic, and
// a FRAME_LEN=1 instance exercising frame counter wrap.
module tb_parity_frame_gen;

    localparam int WIDTH = 8;
    localparam int FLEN  = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main DUT (FRAME_LEN=4) ----------------
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             odd_sel = 1'b0;
    logic             frame_abort = 1'b0;
    logic             par_valid;
    logic             par_ready = 1'b1;
    logic             par_bit;
    logic [CNT_W-1:0] frame_cnt;
    logic             chk_bit = 1'b0;
`ifdef PARITY_FRAME_CHECK_EN
    logic             par_err;
`endif

    parity_frame_gen #(.WIDTH(WIDTH), .FRAME_LEN(FLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .odd_sel(odd_sel), .frame_abort(frame_abort),
        .par_valid(par_valid), .par_ready(par_ready), .par_bit(par_bit),
`ifdef PARITY_FRAME_CHECK_EN
        .chk_bit(chk_bit), .par_err(par_err),
`endif
        .frame_cnt(frame_cnt)
    );

    // ---------------- FRAME_LEN=1 DUT ----------------
    logic             rst1 = 1'b1;
    logic             v1 = 1'b0;
    logic             rdy1;
    logic [WIDTH-1:0] d1 = 8'h07;
    logic             pv1;
    logic             pb1;
    logic [CNT_W-1:0] fc1;
    logic             chk1 = 1'b1;
`ifdef PARITY_FRAME_CHECK_EN
    logic             err1;
`endif

    parity_frame_gen #(.WIDTH(WIDTH), .FRAME_LEN(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst1),
        .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .odd_sel(1'b1), .frame_abort(1'b0),
        .par_valid(pv1), .par_ready(1'b1), .par_bit(pb1),
`ifdef PARITY_FRAME_CHECK_EN
        .chk_bit(chk1), .par_err(err1),
`endif
        .frame_cnt(fc1)
    );

    // ---------------- behavioural model ----------------
    bit             m_started;
    bit             m_hold;
    logic [WIDTH-1:0] m_words[$];
    bit             m_mode;
    bit             m_pbit;
    bit             m_err;
    int             m_cnt;

    function automatic void model_reset();
        m_started = 0; m_hold = 0; m_words.delete();
        m_mode = 0; m_pbit = 0; m_err = 0; m_cnt = 0;
    endfunction

    // Advance the model at each rising edge, then compare at the falling edge.
    initial begin
        int ones;
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else if (!m_started) begin
                m_started = 1;
            end else if (m_hold) begin
                if (par_ready) m_hold = 0;
            end else if (frame_abort) begin
                m_words.delete();
            end else if (in_valid) begin
                if (m_words.size() == 0) m_mode = odd_sel;
                m_words.push_back(in_data);
                if (m_words.size() == FLEN) begin
                    ones = 0;
                    foreach (m_words[i]) ones += $countones(m_words[i]);
                    // odd: total ones including parity bit is odd
                    m_pbit = m_mode ? (ones % 2 == 0) : (ones % 2 == 1);
                    m_err  = (chk_bit != m_pbit);
                    m_hold = 1;
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                    m_words.delete();
                end
            end
            @(negedge clk);
            if (rst) model_reset();
            check("in_ready", int'(in_ready), int'(m_started && !m_hold));
            check("par_valid", int'(par_valid), int'(m_hold));
            check("frame_cnt", int'(frame_cnt), m_cnt);
            if (m_hold) check("par_bit", int'(par_bit), int'(m_pbit));
            if (rst) check("par_bit_rst", int'(par_bit), 0);
`ifdef PARITY_FRAME_CHECK_EN
            check("par_err", int'(par_err), int'(m_hold && m_err));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [WIDTH-1:0] d, input bit o);
        bit took;
        int n;
        in_valid = 1'b1; in_data = d; odd_sel = o;
        n = 0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #2;
            n++;
        end while (!took && n < 50);
        if (!took) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_par();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!par_valid && n < 20);
        if (!par_valid) check("par_timeout", 0, 1);
    endtask

    bit done1 = 0;

    // FRAME_LEN=1: 256 words of 0x07 in odd mode, counter wraps to 0.
    initial begin
        int outs;
        int cyc;
        repeat (3) @(posedge clk);
        #2 rst1 = 1'b0;
        v1 = 1'b1;
        outs = 0; cyc = 0;
        while (outs < 256 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (pv1) begin
                outs++;
                check("fl1_par_bit", int'(pb1), 0);
                check("fl1_frame_cnt", int'(fc1), outs % 256);
`ifdef PARITY_FRAME_CHECK_EN
                check("fl1_par_err", int'(err1), 1);
`endif
            end
        end
        v1 = 1'b0;
        check("fl1_outputs", outs, 256);
        repeat (4) @(negedge clk);
        check("fl1_wrap", int'(fc1), 0);
        check("fl1_idle_valid", int'(pv1), 0);
        done1 = 1;
    end

    // ---------------- main stimulus ----------------
    initial begin
        int n;
        // reset
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_par_valid", int'(par_valid), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #2;

        // odd: 11 ones -> 0
        send(8'h01, 1); send(8'h03, 1); send(8'h00, 1); send(8'hFF, 1);
        wait_par();
        check("odd_par_bit", int'(par_bit), 0);
        check("odd_frame_cnt", int'(frame_cnt), 1);
        @(posedge clk); #2;

        // even: same words -> 1
        send(8'h01, 0); send(8'h03, 0); send(8'h00, 0); send(8'hFF, 0);
        wait_par();
        check("even_par_bit", int'(par_bit), 1);
        check("even_frame_cnt", int'(frame_cnt), 2);
        @(posedge clk); #2;

        // mode latched from first word
        send(8'h00, 1); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        wait_par();
        check("latch_par_bit", int'(par_bit), 1);
        @(posedge clk); #2;

        // abort a partial frame, then a full odd frame
        send(8'hFF, 1); send(8'h01, 1);
        frame_abort = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        @(posedge clk); #2;
        frame_abort = 1'b0; in_valid = 1'b0;
        send(8'h80, 1); send(8'h00, 1); send(8'h00, 1); send(8'h00, 1);
        wait_par();
        check("abort_par_bit", int'(par_bit), 0);
        check("abort_frame_cnt", int'(frame_cnt), 4);
        @(posedge clk); #2;

        // backpressure
        par_ready = 1'b0;
        send(8'h01, 1); send(8'h03, 1); send(8'h00, 1); send(8'hFF, 1);
        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_par_valid", int'(par_valid), 1);
            check("bp_par_bit", int'(par_bit), 0);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #2 par_ready = 1'b1;
        @(posedge clk); #2 in_valid = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_frame_cnt", int'(frame_cnt), 5);

        // random traffic, with one mid-frame reset
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = WIDTH'($urandom());
            odd_sel     = $urandom_range(0, 1) == 1;
            frame_abort = ($urandom_range(0, 19) == 0);
            par_ready   = ($urandom_range(0, 9) < 7);
            chk_bit     = $urandom_range(0, 1) == 1;
            rst         = (c == 300);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; frame_abort = 1'b0; par_ready = 1'b1; rst = 1'b0;

        n = 0;
        while (!done1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("fl1_done", int'(done1), 1);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
